i2s_rx_sampler: RTL and testbench
=================================

Name: i2s_rx_sampler

Overview:
- Upstream input stage for the high-pass SOS filter chain.
- Receives serial audio from an external ADC (I2S: bit clock, word select, serial data), all asynchronous to the system clock.
- Extracts one selected channel as a DATA_SIZE-bit two's-complement word.
- Presents the word on data_out with a one-cycle sample_trig strobe, directly driving the filter's data_in/sample_trig inputs.

Parameters:
- DATA_SIZE, 24: captured word width, equal to the filter DATA_SIZE.
- CHANNEL, 0: captured channel. 0 = left (lrclk low), 1 = right (lrclk high).

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- i2s_bclk  input  1  I2S bit clock, asynchronous.
- i2s_lrclk  input  1  I2S word select, asynchronous.
- i2s_sdata  input  1  I2S serial data, MSB first, asynchronous.
- data_out  output  DATA_SIZE  last complete sample of the selected channel.
- sample_trig  output  1  one-clk pulse: data_out is newly updated.
- frame_err  output  1  one-clk pulse: the selected-channel frame ended short.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - data_out=0, sample_trig=0, frame_err=0;
  - all synchroniser, edge-detect and shift registers to 0;
  - bit counter to 0;
  - state to IDLE.
- Synchronisers: i2s_bclk, i2s_lrclk and i2s_sdata each pass through 2 flip-flops, giving bclk_s, lrclk_s and sdata_s.
- Bit-edge detection: bclk_d is bclk_s delayed by one clk. A bit-edge (be) is bclk_s=1 && bclk_d=0.
- lrclk_s and sdata_s are sampled only in a be cycle.
- lrclk_p holds lrclk_s from the previous be.
- Timing requirement: clk ≥ 4× bclk frequency, and bclk high/low each ≥ 2 clk periods. Behaviour outside this is undefined.
- FSM (IDLE, WAIT, SHIFT); transitions evaluated only in be cycles:
  - IDLE: on the first be, load lrclk_p from lrclk_s and go to WAIT. No capture in IDLE; this prevents a partial frame after reset.
  - WAIT: if lrclk_s != lrclk_p and lrclk_s == CHANNEL, go to SHIFT with count=0. Otherwise stay in WAIT. This edge's sdata is the previous slot's LSB and is discarded (standard I2S 1-bit delay).
  - SHIFT: shift sdata_s into the LSB of the shift register and increment count.
    - When the DATA_SIZE-th bit (count = DATA_SIZE-1) is shifted: in the next clk, load data_out from the full register, pulse sample_trig=1 for exactly one clk, and go to WAIT.
  - Short frame: in SHIFT, if lrclk_s != lrclk_p before DATA_SIZE bits are captured:
    - pulse frame_err for one clk;
    - leave data_out unchanged and do not pulse sample_trig;
    - evaluate the edge as in WAIT, i.e. restart only if the new lrclk_s == CHANNEL.
  - Long slots (e.g. 32-bit slot, 24-bit word): bits after the DATA_SIZE-th are ignored while in WAIT.
- lrclk_p updates on every be, in every state except IDLE (where it is loaded as above).
- Latency: sample_trig rises exactly 1 clk after the be cycle that captures the LSB. data_out is valid in the same cycle as sample_trig and holds until the next valid capture.
- sample_trig and frame_err never assert in the same cycle. There is at most one sample_trig per lrclk period.
- Data is passed through bit-exact, with no sign manipulation: the first received bit becomes data_out[DATA_SIZE-1].
- Reset mid-frame: outputs clear immediately. After release the FSM re-enters IDLE and captures only from the next selected-channel lrclk transition onward.

Test Plan:
- Reset: drive reset=0 with bclk running → data_out=0, sample_trig=0 and frame_err=0 throughout. After release, no sample_trig until one full left frame completes.
- Nominal (CHANNEL=0, clk 100 MHz, bclk=clk/8, 32-bit slots): left=24'hA5C3F1, right=24'h123456 → data_out=24'hA5C3F1, exactly one sample_trig per frame, 1 clk after the LSB be. Right data never appears.
- Extremes back-to-back: left frames 24'h800000 then 24'h7FFFFF → two sample_trig pulses with exactly those values. data_out is stable between pulses.
- Short frame: after a good frame 24'h0F0F0F, lrclk toggles after 16 bits of a new left frame → one frame_err pulse, no sample_trig, data_out stays 24'h0F0F0F. The following full frame 24'h00ABCD is captured correctly.
- Reset at bit 10 of a left frame → outputs 0 immediately. Release with lrclk already low → no spurious capture. The first output is the next complete left frame.
- CHANNEL=1 build: same stimulus as the nominal test → data_out=24'h123456, one pulse per frame, left data never appears.

Source files
------------

// File: rtl/i2s_rx_sampler.sv
// I2S receiver front end: synchronises the bit-clock domain into clk, captures one
// channel MSB-first and presents it as a DATA_SIZE-bit word with a one-cycle strobe.
module i2s_rx_sampler #(
    parameter int DATA_SIZE = 24,
    parameter bit CHANNEL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i2s_bclk,
    input  logic                 i2s_lrclk,
    input  logic                 i2s_sdata,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 sample_trig,
    output logic                 frame_err
);

    localparam int CW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SHIFT
    } state_t;

    logic [1:0] bclk_sync_q, lrclk_sync_q, sdata_sync_q;
    logic       bclk_d_q;
    logic       bclk_s, lrclk_s, sdata_s;
    logic       be, lr_edge;

    state_t               state_q, state_d;
    logic                 lrclk_p_q, lrclk_p_d;
    logic [CW-1:0]        count_q, count_d;
    // Holds every bit except the LSB; the LSB goes straight into data_out.
    logic [DATA_SIZE-2:0] shift_q, shift_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 trig_q, trig_d;
    logic                 err_q, err_d;

    assign bclk_s  = bclk_sync_q[1];
    assign lrclk_s = lrclk_sync_q[1];
    assign sdata_s = sdata_sync_q[1];
    assign be      = bclk_s & ~bclk_d_q;
    assign lr_edge = (lrclk_s != lrclk_p_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdata_sync_q <= '0;
            bclk_d_q     <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[0], i2s_bclk};
            lrclk_sync_q <= {lrclk_sync_q[0], i2s_lrclk};
            sdata_sync_q <= {sdata_sync_q[0], i2s_sdata};
            bclk_d_q     <= bclk_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            lrclk_p_q <= 1'b0;
            count_q   <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            trig_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lrclk_p_q <= lrclk_p_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            trig_q    <= trig_d;
            err_q     <= err_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the
    // block leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        lrclk_p_d = lrclk_p_q;
        count_d   = count_q;
        shift_d   = shift_q;
        data_d    = data_q;
        trig_d    = 1'b0;
        err_d     = 1'b0;

        if (be) begin
            lrclk_p_d = lrclk_s;
            unique case (state_q)
                ST_IDLE: state_d = ST_WAIT;
                // The bit on the word-select edge is the previous slot's LSB.
                ST_WAIT: begin
                    if (lr_edge && (lrclk_s == CHANNEL)) begin
                        state_d = ST_SHIFT;
                        count_d = '0;
                    end
                end
                ST_SHIFT: begin
                    if (lr_edge) begin
                        err_d   = 1'b1;
                        count_d = '0;
                        if (lrclk_s != CHANNEL) begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        shift_d = {shift_q[DATA_SIZE-3:0], sdata_s};
                        count_d = count_q + CW'(1);
                        if (count_q == LAST_BIT) begin
                            data_d  = {shift_q, sdata_s};
                            trig_d  = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign data_out    = data_q;
    assign sample_trig = trig_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_i2s_rx_sampler.sv
// Directed bench: a left-channel and a right-channel sampler share one I2S stream
// built from 32-bit slots with bclk = clk/8.
module tb_i2s_rx_sampler;

    localparam int DS = 24;

    logic          clk = 1'b0;
    logic          reset, bclk, lrclk, sdata;
    logic [DS-1:0] data0, data1;
    logic          trig0, err0, trig1, err1;

    always #5 clk = ~clk;

    i2s_rx_sampler #(.DATA_SIZE(DS), .CHANNEL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
        .data_out(data0), .sample_trig(trig0), .frame_err(err0)
    );

    i2s_rx_sampler #(.DATA_SIZE(DS), .CHANNEL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
        .data_out(data1), .sample_trig(trig1), .frame_err(err1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int trig0_cnt = 0, trig1_cnt = 0, err0_cnt = 0, err1_cnt = 0, overlap_cnt = 0;
    int c0, c1, e0, e1;

    always @(negedge clk) begin
        if (trig0) trig0_cnt++;
        if (trig1) trig1_cnt++;
        if (err0) err0_cnt++;
        if (err1) err1_cnt++;
        if ((trig0 && err0) || (trig1 && err1)) overlap_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bit period: data changes while bclk is low, sampled on the rising edge.
    task automatic send_bit(input logic l, input logic d);
        bclk  = 1'b0;
        lrclk = l;
        sdata = d;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Slot position 0 carries the previous slot's LSB; the word sits at 1..DS.
    task automatic send_bits(input logic l, input logic [DS-1:0] v, input int from, input int to);
        for (int i = from; i <= to; i++)
            send_bit(l, (i >= 1 && i <= DS) ? v[DS-i] : 1'b0);
    endtask

    task automatic send_frame(input logic [DS-1:0] left, input logic [DS-1:0] right);
        send_bits(1'b0, left, 0, 31);
        send_bits(1'b1, right, 0, 31);
    endtask

    task automatic snap();
        c0 = trig0_cnt; c1 = trig1_cnt; e0 = err0_cnt; e1 = err1_cnt;
    endtask

    task automatic check_frame(input string name, input logic [DS-1:0] exp0, input logic [DS-1:0] exp1,
                               input int dt0, input int dt1, input int de0);
        check({name, "_data_l"}, 32'(data0), 32'(exp0));
        check({name, "_data_r"}, 32'(data1), 32'(exp1));
        check({name, "_trig_l"}, trig0_cnt - c0, dt0);
        check({name, "_trig_r"}, trig1_cnt - c1, dt1);
        check({name, "_err_l"}, err0_cnt - e0, de0);
        check({name, "_err_r"}, err1_cnt - e1, 0);
    endtask

    typedef struct {
        logic [DS-1:0] left;
        logic [DS-1:0] right;
        logic [DS-1:0] exp_l;
        logic [DS-1:0] exp_r;
    } vec_t;

    vec_t vecs[4];
    logic [DS-1:0] v;

    initial begin
        vecs[0] = '{24'hA5C3F1, 24'h123456, 24'hA5C3F1, 24'h123456};
        vecs[1] = '{24'h800000, 24'h0F0F0F, 24'h800000, 24'h0F0F0F};
        vecs[2] = '{24'h7FFFFF, 24'hFFFFFF, 24'h7FFFFF, 24'hFFFFFF};
        vecs[3] = '{24'h0F0F0F, 24'h000001, 24'h0F0F0F, 24'h000001};

        reset = 1'b0;
        bclk  = 1'b0;
        lrclk = 1'b1;
        sdata = 1'b0;
        @(negedge clk);

        // Bit clock running while held in reset.
        send_bits(1'b1, 24'hFFFFFF, 0, 7);
        send_bits(1'b0, 24'hFFFFFF, 0, 7);
        check("rst_data_l", 32'(data0), 32'h0);
        check("rst_data_r", 32'(data1), 32'h0);
        check("rst_trig", trig0_cnt + trig1_cnt, 0);
        check("rst_err", err0_cnt + err1_cnt, 0);

        // Released mid left slot: no left capture until a full left frame.
        reset = 1'b1;
        snap();
        send_frame(24'h111111, 24'h222222);
        check_frame("prime", 24'h000000, 24'h222222, 0, 1, 0);

        // Latency: strobe visible on the 3rd falling clk edge after the LSB bclk rise.
        snap();
        v = 24'h3C3C3D;
        send_bits(1'b0, v, 0, DS - 1);
        bclk  = 1'b0;
        lrclk = 1'b0;
        sdata = v[0];
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (2) @(negedge clk);
        check("lat_pre", 32'(trig0), 32'h0);
        @(negedge clk);
        check("lat_pulse", 32'(trig0), 32'h1);
        check("lat_data", 32'(data0), 32'h3C3C3D);
        @(negedge clk);
        check("lat_post", 32'(trig0), 32'h0);
        send_bits(1'b0, v, DS + 1, 31);
        send_bits(1'b1, 24'h654321, 0, 31);
        check_frame("lat", 24'h3C3C3D, 24'h654321, 1, 1, 0);

        for (int i = 0; i < 4; i++) begin
            snap();
            send_frame(vecs[i].left, vecs[i].right);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r, 1, 1, 0);
        end

        // Left slot cut after 16 bits.
        snap();
        send_bits(1'b0, 24'hFFFF00, 0, 16);
        send_bits(1'b1, 24'h333333, 0, 31);
        check_frame("short", 24'h0F0F0F, 24'h333333, 0, 1, 1);
        snap();
        send_frame(24'h00ABCD, 24'h444444);
        check_frame("after_short", 24'h00ABCD, 24'h444444, 1, 1, 0);

        // Reset at bit 10 of a left frame, released with lrclk still low.
        send_bits(1'b0, 24'hC3C3C3, 0, 10);
        reset = 1'b0;
        #1;
        check("midrst_data_l", 32'(data0), 32'h0);
        check("midrst_data_r", 32'(data1), 32'h0);
        check("midrst_trig", 32'(trig0 | trig1), 32'h0);
        check("midrst_err", 32'(err0 | err1), 32'h0);
        send_bits(1'b0, 24'hC3C3C3, 11, 14);
        reset = 1'b1;
        snap();
        send_bits(1'b0, 24'hC3C3C3, 15, 31);
        send_bits(1'b1, 24'h777777, 0, 31);
        check_frame("post_rst", 24'h000000, 24'h777777, 0, 1, 0);
        snap();
        send_frame(24'h5A5A5A, 24'h6B6B6B);
        check_frame("first_after_rst", 24'h5A5A5A, 24'h6B6B6B, 1, 1, 0);

        check("trig_err_exclusive", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
